// File: rtl/nes_multi_pad_reader.sv
`default_nettype none
// ============================================================================
// Module      : nes_multi_pad_reader
// Description : Polls 1..4 NES controllers over a shared latch/pulse pair,
//               samples every pad's serial line in parallel, detects
//               plugged-in pads and publishes buttons, new presses and a
//               one-cycle valid strobe.
// Revision    : 1.0 - initial release
// ============================================================================
module nes_multi_pad_reader #(
  parameter int NUM_PADS    = 2,
  parameter int CLK_DIV     = 150,
  parameter int SYNC_STAGES = 2
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    start,
  input  logic [NUM_PADS-1:0]     pad_data,
  output logic                    pad_latch,
  output logic                    pad_pulse,
  output logic                    busy,
  output logic                    valid,
  output logic                    overrun,
  output logic [8*NUM_PADS-1:0]   buttons,
  output logic [8*NUM_PADS-1:0]   pressed,
  output logic [NUM_PADS-1:0]     present
);

  localparam int                DIV_W    = $clog2(CLK_DIV);
  localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [3:0]        IDX_LAST = 4'd8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LATCH   = 2'd1,
    READ_LO = 2'd2,
    READ_HI = 2'd3
  } state_t;

  state_t                               state_q, state_d;
  logic [DIV_W-1:0]                     div_q, div_d;
  logic [3:0]                           idx_q, idx_d;
  logic                                 lat_half_q, lat_half_d;
  logic [SYNC_STAGES-1:0][NUM_PADS-1:0] sync_q, sync_d;
  logic [8*NUM_PADS-1:0]                shift_q, shift_d;
  logic [8*NUM_PADS-1:0]                buttons_q, buttons_d;
  logic [8*NUM_PADS-1:0]                pressed_q, pressed_d;
  logic [NUM_PADS-1:0]                  present_q, present_d;
  logic                                 valid_q, valid_d;
  logic                                 overrun_q, overrun_d;
  logic                                 latch_q, latch_d;
  logic                                 pulse_q, pulse_d;
  logic                                 busy_q, busy_d;

  logic                                 tick;
  logic [NUM_PADS-1:0]                  sync_data;
  logic [8*NUM_PADS-1:0]                commit_btn;

  assign tick      = (div_q == DIV_LAST);
  assign sync_data = sync_q[SYNC_STAGES-1];

  // Synchroniser chain: stage 0 captures the raw pad lines, last stage is used.
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], pad_data};
  end

  // Button word to publish at commit; an absent pad (line idles high) reads 0.
  always_comb begin
    commit_btn = '0;
    for (int p = 0; p < NUM_PADS; p++) begin
      commit_btn[8*p +: 8] = sync_data[p] ? 8'h00 : shift_q[8*p +: 8];
    end
  end

  // Poll sequencer: divider, bit index, shift capture, commit and strobes.
  always_comb begin
    state_d    = state_q;
    div_d      = tick ? '0 : div_q + DIV_W'(1);
    idx_d      = idx_q;
    lat_half_d = lat_half_q;
    shift_d    = shift_q;
    buttons_d  = buttons_q;
    pressed_d  = pressed_q;
    present_d  = present_q;
    valid_d    = 1'b0;
    // A request that arrives while a poll is running is dropped and flagged.
    overrun_d  = start && (state_q != IDLE);

    case (state_q)
      IDLE: begin
        div_d = '0;
        if (start) begin
          state_d    = LATCH;
          idx_d      = 4'd0;
          lat_half_d = 1'b0;
        end
      end
      LATCH: begin
        if (tick) begin
          if (lat_half_q) begin
            state_d = READ_LO;
          end else begin
            lat_half_d = 1'b1;
          end
        end
      end
      READ_LO: begin
        if (tick) begin
          if (idx_q == IDX_LAST) begin
            // After 8 shifts a real pad outputs its tied-low serial input.
            state_d   = IDLE;
            present_d = ~sync_data;
            buttons_d = commit_btn;
            pressed_d = commit_btn & ~buttons_q;
            valid_d   = 1'b1;
          end else begin
            for (int p = 0; p < NUM_PADS; p++) begin
              shift_d[8*p + int'(idx_q[2:0])] = ~sync_data[p];
            end
            state_d = READ_HI;
          end
        end
      end
      READ_HI: begin
        if (tick) begin
          idx_d   = idx_q + 4'd1;
          state_d = READ_LO;
        end
      end
      default: state_d = IDLE;
    endcase

    // Pad-facing lines are decoded from the next state so they leave a flop.
    latch_d = (state_d == LATCH);
    pulse_d = (state_d == READ_HI);
    busy_d  = (state_d != IDLE);
  end

  // State and datapath registers; reset aborts any poll immediately.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      div_q      <= '0;
      idx_q      <= '0;
      lat_half_q <= 1'b0;
      sync_q     <= '0;
      shift_q    <= '0;
      buttons_q  <= '0;
      pressed_q  <= '0;
      present_q  <= '0;
      valid_q    <= 1'b0;
      overrun_q  <= 1'b0;
      latch_q    <= 1'b0;
      pulse_q    <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      div_q      <= div_d;
      idx_q      <= idx_d;
      lat_half_q <= lat_half_d;
      sync_q     <= sync_d;
      shift_q    <= shift_d;
      buttons_q  <= buttons_d;
      pressed_q  <= pressed_d;
      present_q  <= present_d;
      valid_q    <= valid_d;
      overrun_q  <= overrun_d;
      latch_q    <= latch_d;
      pulse_q    <= pulse_d;
      busy_q     <= busy_d;
    end
  end

  assign pad_latch = latch_q;
  assign pad_pulse = pulse_q;
  assign busy      = busy_q;
  assign valid     = valid_q;
  assign overrun   = overrun_q;
  assign buttons   = buttons_q;
  assign pressed   = pressed_q;
  assign present   = present_q;

endmodule
`default_nettype wire
